scan_fsm: RTL and testbench
===========================

SCAN_FSM -- requirements
Module: scan_fsm

Interface
REQ-001 Parameter N_ROWS, default 24: number of pixel rows scanned, range 1..32.
REQ-002 Parameter N_COLS, default 24: number of pixel columns scanned, range 1..32.
REQ-003 Parameter SETTLE, default 4: cycles the key is held before sampling, range 1..255.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 i_go  input  1  level from the top-level arbiter; high while this block owns the matrix.
REQ-007 i_adc_data  input  12  pixel conversion result, valid during SAMPLE.
REQ-008 o_col_control  output  5  RAM column-counter command: bit4 clear, bit3 increment, bits2:0 zero.
REQ-009 o_row_control  output  5  RAM row-counter command, same encoding as o_col_control.
REQ-010 o_ram_wren  output  1  RAM write enable.
REQ-011 o_ram_data  output  12  RAM write data.
REQ-012 o_row_reg_data / o_row_reg_write  output  1 each  serial data and shift strobe of the chip row-select register.
REQ-013 o_col_reg_data / o_col_reg_write  output  1 each  serial data and shift strobe of the chip column-select register.
REQ-014 o_key_wren  output  1  pixel key enable.
REQ-015 o_row_rst  output  1  row reset pulse after each row.
REQ-016 o_scan_end  output  1  scan-complete handshake to the arbiter.

Function
REQ-017 States SHALL be IDLE, ROW_SHIFT, COL_SHIFT, SETTLE, SAMPLE, WRITE, ROW_RST, DONE; outputs are decoded from the state register and counters only (Moore).
REQ-018 IDLE: o_col_control = o_row_control = 5'b10000, all other outputs 0; i_go high at a clock edge -> ROW_SHIFT, row = col = 0.
REQ-019 ROW_SHIFT (1 cycle): o_row_reg_write = 1, o_row_reg_data = (row == 0), o_col_control = 5'b10000 -> COL_SHIFT.
REQ-020 COL_SHIFT (1 cycle): o_col_reg_write = 1, o_col_reg_data = (col == 0) -> SETTLE with settle counter = 0.
REQ-021 SETTLE: o_key_wren = 1 for exactly SETTLE cycles -> SAMPLE.
REQ-022 SAMPLE (1 cycle): o_key_wren = 1; i_adc_data is registered at the end of the cycle -> WRITE.
REQ-023 WRITE (1 cycle): o_ram_wren = 1, o_ram_data = registered sample, o_col_control = 5'b01000; col < N_COLS-1 -> col+1, COL_SHIFT; otherwise -> ROW_RST.
REQ-024 ROW_RST (1 cycle): o_row_rst = 1, o_row_control = 5'b01000, o_col_control = 5'b10000; row < N_ROWS-1 -> row+1, col = 0, ROW_SHIFT; otherwise -> DONE.
REQ-025 DONE: o_scan_end = 1 and all other strobes 0; the block stays in DONE while i_go = 1 and returns to IDLE on the first edge with i_go = 0.
REQ-026 Outputs not listed for a state SHALL be 0; o_ram_data holds its last value outside WRITE.
REQ-027 Each pixel SHALL take SETTLE+3 cycles; each row N_COLS*(SETTLE+3)+2 cycles; o_scan_end first rises N_ROWS*(N_COLS*(SETTLE+3)+2)+1 cycles after the edge that samples i_go high.
REQ-028 Abort: i_go = 0 in any state other than IDLE or DONE -> IDLE on the next edge with counters cleared; no RAM write and no o_scan_end in that cycle.
REQ-029 Exactly one o_ram_wren pulse per pixel, N_ROWS*N_COLS pulses per complete scan, in row-major order.
REQ-030 Row and column counters are 5 bits wide; the parameter ranges rule out wrap-around.

Reset
REQ-031 rst high SHALL force IDLE asynchronously at any time, clearing the row, column and settle counters, the sample register and o_ram_data to 0, with outputs at IDLE values.
REQ-032 After rst falls, i_go held high SHALL start a fresh scan from row 0, column 0; no partial scan is resumed.

Verification
REQ-033 N_ROWS=2, N_COLS=2, SETTLE=1, i_go held high -> 4 o_ram_wren pulses, o_scan_end rises on cycle 21 after go is sampled, and holds until i_go falls.
REQ-034 ADC stimulus 12'h001..12'h004 per pixel -> RAM write data 001, 002, 003, 004 in order; o_row_reg_data = 1 only on the first ROW_SHIFT; o_col_reg_data = 1 only on col 0 of each row.
REQ-035 i_go dropped during the SETTLE of pixel (0,1) -> IDLE next cycle; 1 write total; no o_scan_end; a following go restarts at (0,0).
REQ-036 rst pulsed asynchronously mid-WRITE -> o_ram_wren drops immediately and all outputs take IDLE values.
REQ-037 N_ROWS=1, N_COLS=1, SETTLE=1 -> one write, one o_row_rst pulse, o_scan_end rises on cycle 7.
REQ-038 Per-cycle checks on default parameters: o_key_wren high for exactly SETTLE+1 cycles per pixel; o_row_rst pulses N_ROWS times.

Source files
------------

// File: rtl/scan_fsm.sv
// Pixel-matrix scan sequencer: walks rows and columns, settles each key,
// samples the ADC and writes one RAM word per pixel in row-major order.
module scan_fsm #(
  parameter int N_ROWS = 24,
  parameter int N_COLS = 24,
  parameter int SETTLE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_go,
  input  logic [11:0] i_adc_data,
  output logic [4:0]  o_col_control,
  output logic [4:0]  o_row_control,
  output logic        o_ram_wren,
  output logic [11:0] o_ram_data,
  output logic        o_row_reg_data,
  output logic        o_row_reg_write,
  output logic        o_col_reg_data,
  output logic        o_col_reg_write,
  output logic        o_key_wren,
  output logic        o_row_rst,
  output logic        o_scan_end,
  output logic [2:0]  o_dbg_state
);

  // Handshake with the arbiter: i_go is a level request held high while this
  // block owns the matrix; o_scan_end is a level acknowledge asserted in DONE
  // and held until i_go falls. Dropping i_go mid-scan aborts to IDLE.

  localparam logic [4:0] LAST_ROW    = 5'(N_ROWS - 1);
  localparam logic [4:0] LAST_COL    = 5'(N_COLS - 1);
  localparam logic [7:0] LAST_SETTLE = 8'(SETTLE - 1);
  localparam logic [4:0] CTRL_CLEAR  = 5'b10000;
  localparam logic [4:0] CTRL_INC    = 5'b01000;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ROW_SHIFT = 3'd1,
    S_COL_SHIFT = 3'd2,
    S_SETTLE    = 3'd3,
    S_SAMPLE    = 3'd4,
    S_WRITE     = 3'd5,
    S_ROW_RST   = 3'd6,
    S_DONE      = 3'd7
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  row_q, row_d;
  logic [4:0]  col_q, col_d;
  logic [7:0]  settle_q, settle_d;
  logic [11:0] sample_q;
  logic [11:0] ram_data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      row_q    <= '0;
      col_q    <= '0;
      settle_q <= '0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      col_q    <= col_d;
      settle_q <= settle_d;
    end
  end

  // The ADC word is captured at the end of SAMPLE; the RAM data output only
  // adopts it during WRITE so an aborted sample never appears on o_ram_data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_q   <= '0;
      ram_data_q <= '0;
    end else begin
      if (state_q == S_SAMPLE) sample_q <= i_adc_data;
      if (state_q == S_WRITE)  ram_data_q <= sample_q;
    end
  end

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    col_d    = col_q;
    settle_d = settle_q;
    case (state_q)
      S_IDLE: begin
        row_d    = '0;
        col_d    = '0;
        settle_d = '0;
        if (i_go) state_d = S_ROW_SHIFT;
      end
      S_ROW_SHIFT: state_d = S_COL_SHIFT;
      S_COL_SHIFT: begin
        settle_d = '0;
        state_d  = S_SETTLE;
      end
      S_SETTLE: begin
        if (settle_q == LAST_SETTLE) state_d = S_SAMPLE;
        else                         settle_d = settle_q + 8'd1;
      end
      S_SAMPLE: state_d = S_WRITE;
      S_WRITE: begin
        if (col_q < LAST_COL) begin
          col_d   = col_q + 5'd1;
          state_d = S_COL_SHIFT;
        end else begin
          state_d = S_ROW_RST;
        end
      end
      S_ROW_RST: begin
        if (row_q < LAST_ROW) begin
          row_d   = row_q + 5'd1;
          col_d   = '0;
          state_d = S_ROW_SHIFT;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE: if (!i_go) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Losing the matrix mid-scan discards all progress.
    if (!i_go && state_q != S_IDLE && state_q != S_DONE) begin
      state_d  = S_IDLE;
      row_d    = '0;
      col_d    = '0;
      settle_d = '0;
    end
  end

  always_comb begin
    o_col_control   = '0;
    o_row_control   = '0;
    o_ram_wren      = 1'b0;
    o_row_reg_data  = 1'b0;
    o_row_reg_write = 1'b0;
    o_col_reg_data  = 1'b0;
    o_col_reg_write = 1'b0;
    o_key_wren      = 1'b0;
    o_row_rst       = 1'b0;
    o_scan_end      = 1'b0;
    case (state_q)
      S_IDLE: begin
        o_col_control = CTRL_CLEAR;
        o_row_control = CTRL_CLEAR;
      end
      S_ROW_SHIFT: begin
        o_row_reg_write = 1'b1;
        o_row_reg_data  = (row_q == 5'd0);
        o_col_control   = CTRL_CLEAR;
      end
      S_COL_SHIFT: begin
        o_col_reg_write = 1'b1;
        o_col_reg_data  = (col_q == 5'd0);
      end
      S_SETTLE: o_key_wren = 1'b1;
      S_SAMPLE: o_key_wren = 1'b1;
      S_WRITE: begin
        o_ram_wren    = 1'b1;
        o_col_control = CTRL_INC;
      end
      S_ROW_RST: begin
        o_row_rst     = 1'b1;
        o_row_control = CTRL_INC;
        o_col_control = CTRL_CLEAR;
      end
      S_DONE: o_scan_end = 1'b1;
      default: ;
    endcase
  end

  assign o_ram_data  = (state_q == S_WRITE) ? sample_q : ram_data_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_scan_fsm.sv
// Directed bench for scan_fsm: three instances (2x2/S1, 1x1/S1, defaults)
// share clock and reset; each scenario task checks its own results inline.
module tb_scan_fsm;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        go_a = 1'b0, go_b = 1'b0, go_c = 1'b0;
  logic [11:0] adc_a = '0, adc_b = '0, adc_c = '0;

  logic [4:0]  a_col_control, a_row_control, b_col_control, b_row_control, c_col_control, c_row_control;
  logic        a_ram_wren, b_ram_wren, c_ram_wren;
  logic [11:0] a_ram_data, b_ram_data, c_ram_data;
  logic        a_row_reg_data, a_row_reg_write, a_col_reg_data, a_col_reg_write;
  logic        b_row_reg_data, b_row_reg_write, b_col_reg_data, b_col_reg_write;
  logic        c_row_reg_data, c_row_reg_write, c_col_reg_data, c_col_reg_write;
  logic        a_key_wren, a_row_rst, a_scan_end, b_key_wren, b_row_rst, b_scan_end;
  logic        c_key_wren, c_row_rst, c_scan_end;
  logic [2:0]  a_dbg_state, b_dbg_state, c_dbg_state;

  scan_fsm #(.N_ROWS(2), .N_COLS(2), .SETTLE(1)) dut_a (
    .clk(clk), .rst(rst), .i_go(go_a), .i_adc_data(adc_a),
    .o_col_control(a_col_control), .o_row_control(a_row_control),
    .o_ram_wren(a_ram_wren), .o_ram_data(a_ram_data),
    .o_row_reg_data(a_row_reg_data), .o_row_reg_write(a_row_reg_write),
    .o_col_reg_data(a_col_reg_data), .o_col_reg_write(a_col_reg_write),
    .o_key_wren(a_key_wren), .o_row_rst(a_row_rst), .o_scan_end(a_scan_end),
    .o_dbg_state(a_dbg_state)
  );

  scan_fsm #(.N_ROWS(1), .N_COLS(1), .SETTLE(1)) dut_b (
    .clk(clk), .rst(rst), .i_go(go_b), .i_adc_data(adc_b),
    .o_col_control(b_col_control), .o_row_control(b_row_control),
    .o_ram_wren(b_ram_wren), .o_ram_data(b_ram_data),
    .o_row_reg_data(b_row_reg_data), .o_row_reg_write(b_row_reg_write),
    .o_col_reg_data(b_col_reg_data), .o_col_reg_write(b_col_reg_write),
    .o_key_wren(b_key_wren), .o_row_rst(b_row_rst), .o_scan_end(b_scan_end),
    .o_dbg_state(b_dbg_state)
  );

  scan_fsm dut_c (
    .clk(clk), .rst(rst), .i_go(go_c), .i_adc_data(adc_c),
    .o_col_control(c_col_control), .o_row_control(c_row_control),
    .o_ram_wren(c_ram_wren), .o_ram_data(c_ram_data),
    .o_row_reg_data(c_row_reg_data), .o_row_reg_write(c_row_reg_write),
    .o_col_reg_data(c_col_reg_data), .o_col_reg_write(c_col_reg_write),
    .o_key_wren(c_key_wren), .o_row_rst(c_row_rst), .o_scan_end(c_scan_end),
    .o_dbg_state(c_dbg_state)
  );

  task automatic test_reset;
    rst = 1'b1;
    #3;
    checks++;
    if (a_col_control !== 5'b10000 || a_row_control !== 5'b10000) begin
      errors++; $display("FAIL reset_ctrl: col=%b row=%b expected 10000/10000", a_col_control, a_row_control);
    end
    checks++;
    if ({a_ram_wren, a_key_wren, a_row_rst, a_scan_end, a_row_reg_write, a_col_reg_write} !== 6'b0 || a_ram_data !== 12'h000) begin
      errors++; $display("FAIL reset_outputs: strobes=%b data=%h expected 0", {a_ram_wren, a_key_wren, a_row_rst, a_scan_end, a_row_reg_write, a_col_reg_write}, a_ram_data);
    end
    checks++;
    if (a_dbg_state !== 3'd0 || c_dbg_state !== 3'd0) begin
      errors++; $display("FAIL reset_state: a=%0d c=%0d expected 0", a_dbg_state, c_dbg_state);
    end
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_scan_2x2;
    logic [11:0] exp_q[$];
    logic [11:0] e;
    int wr = 0, rrw = 0, rrd = 0, crw = 0, crd = 0, first_end = 0, end_cycles = 0, bad_ctrl = 0;
    exp_q = {12'h001, 12'h002, 12'h003, 12'h004};
    adc_a = 12'h001;
    @(negedge clk) go_a = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= 40; cyc++) begin
      #1;
      if (a_ram_wren) begin
        wr++;
        if (a_col_control !== 5'b01000) bad_ctrl++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL scan_write_extra: data=%h at cycle %0d, none expected", a_ram_data, cyc);
        end else begin
          e = exp_q.pop_front();
          if (a_ram_data !== e) begin
            errors++; $display("FAIL scan_write_data: got %h expected %h", a_ram_data, e);
          end
        end
        adc_a = adc_a + 12'h001;
      end
      if (a_row_reg_write) begin rrw++; if (a_row_reg_data) rrd++; end
      if (a_col_reg_write) begin crw++; if (a_col_reg_data) crd++; end
      if (a_scan_end) begin end_cycles++; if (first_end == 0) first_end = cyc; end
      @(posedge clk);
    end
    checks++;
    if (wr !== 4) begin errors++; $display("FAIL scan_write_count: got %0d expected 4", wr); end
    checks++;
    if (first_end !== 21) begin errors++; $display("FAIL scan_end_cycle: got %0d expected 21", first_end); end
    checks++;
    if (end_cycles !== 20) begin errors++; $display("FAIL scan_end_hold: got %0d cycles expected 20", end_cycles); end
    checks++;
    if (rrw !== 2 || rrd !== 1) begin errors++; $display("FAIL row_reg_data: writes=%0d ones=%0d expected 2/1", rrw, rrd); end
    checks++;
    if (crw !== 4 || crd !== 2) begin errors++; $display("FAIL col_reg_data: writes=%0d ones=%0d expected 4/2", crw, crd); end
    checks++;
    if (bad_ctrl !== 0) begin errors++; $display("FAIL write_col_ctrl: %0d writes without 01000 expected 0", bad_ctrl); end
    @(negedge clk) go_a = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (a_scan_end !== 1'b0 || a_dbg_state !== 3'd0 || a_col_control !== 5'b10000) begin
      errors++; $display("FAIL scan_release: end=%b state=%0d col=%b expected 0/0/10000", a_scan_end, a_dbg_state, a_col_control);
    end
    checks++;
    if (a_ram_data !== 12'h004) begin errors++; $display("FAIL ram_data_hold: got %h expected 004", a_ram_data); end
  endtask

  task automatic test_abort;
    int wr = 0;
    @(negedge clk) go_a = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= 7; cyc++) begin
      #1;
      if (a_ram_wren) wr++;
      if (cyc < 7) @(posedge clk);
    end
    checks++;
    if (a_key_wren !== 1'b1 || a_dbg_state !== 3'd3) begin
      errors++; $display("FAIL abort_in_settle: key=%b state=%0d expected 1/3", a_key_wren, a_dbg_state);
    end
    go_a = 1'b0;
    for (int cyc = 8; cyc <= 11; cyc++) begin
      @(posedge clk);
      #1;
      if (a_ram_wren) wr++;
      checks++;
      if (a_dbg_state !== 3'd0 || a_scan_end !== 1'b0 || a_key_wren !== 1'b0) begin
        errors++; $display("FAIL abort_idle: cycle %0d state=%0d end=%b key=%b expected 0/0/0", cyc, a_dbg_state, a_scan_end, a_key_wren);
      end
    end
    checks++;
    if (wr !== 1) begin errors++; $display("FAIL abort_writes: got %0d expected 1", wr); end
    adc_a = 12'h055;
    @(negedge clk) go_a = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (a_row_reg_write !== 1'b1 || a_row_reg_data !== 1'b1) begin
      errors++; $display("FAIL restart_row: write=%b data=%b expected 1/1", a_row_reg_write, a_row_reg_data);
    end
    @(posedge clk);
    #1;
    checks++;
    if (a_col_reg_write !== 1'b1 || a_col_reg_data !== 1'b1) begin
      errors++; $display("FAIL restart_col: write=%b data=%b expected 1/1", a_col_reg_write, a_col_reg_data);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (a_ram_wren !== 1'b1 || a_ram_data !== 12'h055) begin
      errors++; $display("FAIL restart_write: wren=%b data=%h expected 1/055", a_ram_wren, a_ram_data);
    end
    @(negedge clk) go_a = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_rst_mid_write;
    adc_a = 12'h0AA;
    @(negedge clk) go_a = 1'b1;
    @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (a_ram_wren !== 1'b1 || a_ram_data !== 12'h0AA) begin
      errors++; $display("FAIL pre_rst_write: wren=%b data=%h expected 1/0aa", a_ram_wren, a_ram_data);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (a_ram_wren !== 1'b0 || a_ram_data !== 12'h000 || a_dbg_state !== 3'd0) begin
      errors++; $display("FAIL rst_async: wren=%b data=%h state=%0d expected 0/000/0", a_ram_wren, a_ram_data, a_dbg_state);
    end
    checks++;
    if (a_col_control !== 5'b10000 || a_row_control !== 5'b10000 || a_key_wren !== 1'b0) begin
      errors++; $display("FAIL rst_idle_ctrl: col=%b row=%b key=%b expected 10000/10000/0", a_col_control, a_row_control, a_key_wren);
    end
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (a_dbg_state !== 3'd1 || a_row_reg_write !== 1'b1 || a_row_reg_data !== 1'b1) begin
      errors++; $display("FAIL rst_fresh_scan: state=%0d write=%b data=%b expected 1/1/1", a_dbg_state, a_row_reg_write, a_row_reg_data);
    end
    @(negedge clk) go_a = 1'b0;
    @(posedge clk);
  endtask

  task automatic test_single_pixel;
    int wr = 0, rrst = 0, first_end = 0;
    logic [11:0] got = '0;
    adc_b = 12'hABC;
    @(negedge clk) go_b = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= 12; cyc++) begin
      #1;
      if (b_ram_wren) begin wr++; got = b_ram_data; end
      if (b_row_rst) rrst++;
      if (b_scan_end && first_end == 0) first_end = cyc;
      @(posedge clk);
    end
    checks++;
    if (wr !== 1 || got !== 12'hABC) begin errors++; $display("FAIL single_write: count=%0d data=%h expected 1/abc", wr, got); end
    checks++;
    if (rrst !== 1) begin errors++; $display("FAIL single_row_rst: got %0d expected 1", rrst); end
    checks++;
    if (first_end !== 7) begin errors++; $display("FAIL single_end_cycle: got %0d expected 7", first_end); end
    @(negedge clk) go_b = 1'b0;
    @(posedge clk);
  endtask

  task automatic test_default_params;
    int wr = 0, rrst = 0, first_end = 0, run = 0, runs = 0, bad_runs = 0;
    adc_c = 12'h3C3;
    @(negedge clk) go_c = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= 4200; cyc++) begin
      #1;
      if (c_key_wren) run++;
      else if (run > 0) begin
        runs++;
        if (run != 5) bad_runs++;
        run = 0;
      end
      if (c_ram_wren) wr++;
      if (c_row_rst) rrst++;
      if (c_scan_end && first_end == 0) first_end = cyc;
      @(posedge clk);
    end
    checks++;
    if (runs !== 576 || bad_runs !== 0) begin
      errors++; $display("FAIL default_key_wren: runs=%0d bad=%0d expected 576/0", runs, bad_runs);
    end
    checks++;
    if (rrst !== 24) begin errors++; $display("FAIL default_row_rst: got %0d expected 24", rrst); end
    checks++;
    if (wr !== 576) begin errors++; $display("FAIL default_writes: got %0d expected 576", wr); end
    checks++;
    if (first_end !== 4081) begin errors++; $display("FAIL default_end_cycle: got %0d expected 4081", first_end); end
    @(negedge clk) go_c = 1'b0;
    @(posedge clk);
  endtask

  initial begin
    test_reset();
    test_scan_2x2();
    test_abort();
    test_rst_mid_write();
    test_single_pixel();
    test_default_params();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
